// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: datapath widths and
// the fetch sequencer state encoding.
package instruction_fetch_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_next_pc_calc.sv
// Combinational next-PC selection for a running fetch unit: sequential
// increment, conditional branch or unconditional jump, absolute or PC-relative.
module next_pc_calc
  import instruction_fetch_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  branch_i,
  input  logic                  jump_i,
  input  logic                  relative_i,
  input  logic                  compareFlag_i,
  input  logic [DATA_WIDTH-1:0] dest_i,
  output logic [DATA_WIDTH-1:0] nextPc_o
);

  logic [DATA_WIDTH-1:0] target;
  logic                  takeTarget;

  // Relative offsets are two's complement, so a plain truncating add wraps both ways.
  assign target     = relative_i ? pc_i + dest_i : dest_i;
  assign takeTarget = jump_i | (branch_i & compareFlag_i);
  assign nextPc_o   = takeTarget ? target : pc_i + DATA_WIDTH'(1);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: owns the PC, the run/halt state machine and
// the saturating retired-instruction counter.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   _start,
  input  logic [DATA_WIDTH-1:0]  _startAddress,
  input  logic                   _stall,
  input  logic                   _halt,
  input  logic                   _branch,
  input  logic                   _jump,
  input  logic                   _relative,
  input  logic [DATA_WIDTH-1:0]  _destBranchJump,
  input  logic                   _compareFlag,
  output logic [DATA_WIDTH-1:0]  pc,
  output logic                   running,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] insnCount
);

  fetch_state_t           state_q;
  logic [DATA_WIDTH-1:0]  pc_q;
  logic [DATA_WIDTH-1:0]  nextPc_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] countInc_d;

  next_pc_calc u_nextPc (
    .pc_i          (pc_q),
    .branch_i      (_branch),
    .jump_i        (_jump),
    .relative_i    (_relative),
    .compareFlag_i (_compareFlag),
    .dest_i        (_destBranchJump),
    .nextPc_o      (nextPc_d)
  );

  assign countInc_d = (count_q == '1) ? count_q : count_q + COUNT_WIDTH'(1);

  // Stall dominates every decode input; a halt still retires its own instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE, HALTED: begin
          if (_start) begin
            pc_q    <= _startAddress;
            count_q <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!_stall) begin
            count_q <= countInc_d;
            if (_halt) begin
              state_q <= HALTED;
            end else begin
              pc_q <= nextPc_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc        = pc_q;
  assign insnCount = count_q;
  assign running   = (state_q == RUN);
  assign done      = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed bench for instruction_fetch against a spec-level
// model of the fetch rules.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stall = 1'b0, halt = 1'b0, branch = 1'b0, jump = 1'b0;
  logic relative = 1'b0, compareFlag = 1'b0;
  logic [7:0] startAddress = '0, dest = '0;
  logic [7:0] pc;
  logic running, done;
  logic [15:0] insnCount;

  int checks = 0, failures = 0;
  int mState = 0, mPc = 0, mCnt = 0;  // 0=idle 1=run 2=halted

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), ._start(start), ._startAddress(startAddress),
    ._stall(stall), ._halt(halt), ._branch(branch), ._jump(jump),
    ._relative(relative), ._destBranchJump(dest), ._compareFlag(compareFlag),
    .pc(pc), .running(running), .done(done), .insnCount(insnCount)
  );

  task automatic clearInputs();
    start = 0; stall = 0; halt = 0; branch = 0; jump = 0;
    relative = 0; compareFlag = 0; startAddress = 0; dest = 0;
  endtask

  // Applies the architectural rules for one rising edge to the model.
  task automatic modelEdge();
    int tgt;
    if (!rst_n) return;
    if (mState != 1) begin
      if (start) begin mPc = startAddress; mCnt = 0; mState = 1; end
    end else if (!stall) begin
      mCnt = (mCnt == 65535) ? 65535 : mCnt + 1;
      tgt = relative ? (mPc + dest) % 256 : dest;
      if (halt) mState = 2;
      else if (jump || (branch && compareFlag)) mPc = tgt;
      else mPc = (mPc + 1) % 256;
    end
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (pc !== 8'h00) begin failures++; $display("[TB] FAIL reset_pc: got %0h expected 0", pc); end
    checks++; if (insnCount !== 16'h0) begin failures++; $display("[TB] FAIL reset_count: got %0h expected 0", insnCount); end
    checks++; if (running !== 1'b0) begin failures++; $display("[TB] FAIL reset_running: got %0b expected 0", running); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    #5 rst_n = 1;
    tick();
    checks++; if (running !== 1'b0 || pc !== 8'h00) begin failures++; $display("[TB] FAIL idle_hold: got running=%0b pc=%0h expected 0/0", running, pc); end
  endtask

  task automatic test_plain_run();
    start = 1; startAddress = 8'h10;
    tick();
    clearInputs();
    checks++; if (pc !== 8'h10) begin failures++; $display("[TB] FAIL start_pc: got %0h expected 10", pc); end
    checks++; if (running !== 1'b1) begin failures++; $display("[TB] FAIL start_running: got %0b expected 1", running); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pc !== 8'(8'h10 + i)) begin failures++; $display("[TB] FAIL plain_pc%0d: got %0h expected %0h", i, pc, 8'h10 + i); end
    end
    checks++; if (insnCount !== 16'd3) begin failures++; $display("[TB] FAIL plain_count: got %0d expected 3", insnCount); end
    checks++; if (running !== 1'b1) begin failures++; $display("[TB] FAIL plain_running: got %0b expected 1", running); end
  endtask

  task automatic test_branch();
    jump = 1; dest = 8'h20;
    tick();
    clearInputs();
    branch = 1; relative = 1; dest = 8'hFC; compareFlag = 1;
    tick();
    checks++; if (pc !== 8'h1C) begin failures++; $display("[TB] FAIL branch_taken: got %0h expected 1c", pc); end
    clearInputs();
    jump = 1; dest = 8'h20;
    tick();
    clearInputs();
    branch = 1; relative = 1; dest = 8'hFC; compareFlag = 0;
    tick();
    checks++; if (pc !== 8'h21) begin failures++; $display("[TB] FAIL branch_not_taken: got %0h expected 21", pc); end
    clearInputs();
  endtask

  task automatic test_wrap_jump();
    jump = 1; dest = 8'hFF;
    tick();
    clearInputs();
    tick();
    checks++; if (pc !== 8'h00) begin failures++; $display("[TB] FAIL pc_wrap: got %0h expected 0", pc); end
    jump = 1; dest = 8'hF0;
    tick();
    relative = 1; dest = 8'h20;
    tick();
    checks++; if (pc !== 8'h10) begin failures++; $display("[TB] FAIL rel_jump_wrap: got %0h expected 10", pc); end
    relative = 0; dest = 8'h05;
    tick();
    checks++; if (pc !== 8'h05) begin failures++; $display("[TB] FAIL abs_jump: got %0h expected 5", pc); end
    relative = 1; dest = 8'h00;
    tick();
    checks++; if (pc !== 8'h05) begin failures++; $display("[TB] FAIL self_loop_pc: got %0h expected 5", pc); end
    checks++; if (insnCount !== 16'(mCnt)) begin failures++; $display("[TB] FAIL self_loop_count: got %0d expected %0d", insnCount, mCnt); end
    clearInputs();
  endtask

  task automatic test_halt_restart();
    jump = 1; dest = 8'h30;
    tick();
    halt = 1; dest = 8'h99;
    tick();
    clearInputs();
    checks++; if (done !== 1'b1 || running !== 1'b0) begin failures++; $display("[TB] FAIL halt_state: got done=%0b running=%0b expected 1/0", done, running); end
    checks++; if (pc !== 8'h30) begin failures++; $display("[TB] FAIL halt_pc: got %0h expected 30", pc); end
    tick();
    checks++; if (pc !== 8'h30 || done !== 1'b1) begin failures++; $display("[TB] FAIL halted_hold: got pc=%0h done=%0b expected 30/1", pc, done); end
    start = 1; startAddress = 8'h00;
    tick();
    clearInputs();
    checks++; if (running !== 1'b1 || pc !== 8'h00) begin failures++; $display("[TB] FAIL restart: got running=%0b pc=%0h expected 1/0", running, pc); end
    checks++; if (insnCount !== 16'd0) begin failures++; $display("[TB] FAIL restart_count: got %0d expected 0", insnCount); end
  endtask

  task automatic test_stall();
    stall = 1; halt = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (pc !== 8'h00 || insnCount !== 16'd0 || running !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold%0d: got pc=%0h count=%0d running=%0b expected 0/0/1", i, pc, insnCount, running); end
    end
    stall = 0;
    tick();
    clearInputs();
    checks++; if (done !== 1'b1 || insnCount !== 16'd1 || pc !== 8'h00) begin failures++; $display("[TB] FAIL stall_release: got done=%0b count=%0d pc=%0h expected 1/1/0", done, insnCount, pc); end
  endtask

  task automatic test_async_reset();
    start = 1; startAddress = 8'h44;
    tick();
    clearInputs();
    checks++; if (pc !== 8'h44 || running !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset: got pc=%0h running=%0b expected 44/1", pc, running); end
    #3;
    rst_n = 0; start = 1; startAddress = 8'h55;
    mState = 0; mPc = 0; mCnt = 0;
    #1;
    checks++; if (pc !== 8'h00 || running !== 1'b0 || done !== 1'b0 || insnCount !== 16'd0) begin failures++; $display("[TB] FAIL async_reset: got pc=%0h run=%0b done=%0b count=%0d expected 0/0/0/0", pc, running, done, insnCount); end
    tick();
    checks++; if (pc !== 8'h00 || running !== 1'b0) begin failures++; $display("[TB] FAIL start_in_reset: got pc=%0h running=%0b expected 0/0", pc, running); end
    #3;
    rst_n = 1; start = 0;
    tick();
    checks++; if (pc !== 8'h00 || running !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset: got pc=%0h running=%0b expected 0/0", pc, running); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0); startAddress = 8'($urandom);
      stall = ($urandom_range(0, 3) == 0); halt = ($urandom_range(0, 15) == 0);
      jump = ($urandom_range(0, 7) == 0); branch = ($urandom_range(0, 3) == 0);
      relative = 1'($urandom); compareFlag = 1'($urandom); dest = 8'($urandom);
      tick();
      checks++; if (pc !== 8'(mPc)) begin failures++; $display("[TB] FAIL rand_pc@%0d: got %0h expected %0h", i, pc, mPc); end
      checks++; if (insnCount !== 16'(mCnt)) begin failures++; $display("[TB] FAIL rand_count@%0d: got %0d expected %0d", i, insnCount, mCnt); end
      checks++; if (running !== (mState == 1)) begin failures++; $display("[TB] FAIL rand_running@%0d: got %0b expected %0b", i, running, mState == 1); end
      checks++; if (done !== (mState == 2)) begin failures++; $display("[TB] FAIL rand_done@%0d: got %0b expected %0b", i, done, mState == 2); end
    end
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_plain_run();
    test_branch();
    test_wrap_jump();
    test_halt_restart();
    test_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port _start, input, 1, one-cycle request to begin execution.
REQ-004 SHALL have port _startAddress, input, DATA_WIDTH, PC loaded on accepted _start.
REQ-005 SHALL have port _stall, input, 1, hold PC; current instruction not retired.
REQ-006 SHALL have port _halt, input, 1, decoded halt from control unit.
REQ-007 SHALL have port _branch, input, 1, decoded conditional branch.
REQ-008 SHALL have port _jump, input, 1, decoded unconditional jump.
REQ-009 SHALL have port _relative, input, 1, 1 = PC-relative target, 0 = absolute.
REQ-010 SHALL have port _destBranchJump, input, DATA_WIDTH, target or signed two's-complement offset.
REQ-011 SHALL have port _compareFlag, input, 1, registered ALU comparison bit; branch condition.
REQ-012 SHALL have port pc, output, DATA_WIDTH, instruction ROM address.
REQ-013 SHALL have port running, output, 1, high in RUN state.
REQ-014 SHALL have port done, output, 1, high in HALTED state.
REQ-015 SHALL have port insnCount, output, COUNT_WIDTH, retired-instruction count.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, HALTED; running/done decoded from state only.
REQ-017 IDLE: _start=1 -> pc <= _startAddress, insnCount <= 0, next state RUN; otherwise hold.
REQ-018 HALTED: _start=1 -> same action as REQ-017 (restart); otherwise hold pc, insnCount.
REQ-019 RUN: _start ignored.
REQ-020 RUN, _stall=1: pc, insnCount, state held; all decode inputs ignored (stall beats halt/branch/jump).
REQ-021 RUN, _stall=0, _halt=1: state <= HALTED, pc held, insnCount += 1; halt beats branch/jump.
REQ-022 RUN, _stall=0, _jump=1: pc <= target.
REQ-023 RUN, _stall=0, _branch=1, _compareFlag=1: pc <= target; _compareFlag=0: pc <= pc+1.
REQ-024 _jump and _branch both high: treat as jump.
REQ-025 target = _relative ? pc + _destBranchJump : _destBranchJump; sum truncated to DATA_WIDTH (modulo wrap both directions).
REQ-026 no control asserted: pc <= pc+1, wrapping all-ones -> 0.
REQ-027 every non-stalled RUN cycle SHALL increment insnCount by 1, saturating at all-ones.
REQ-028 pc change SHALL be visible the cycle after the deciding edge; single-cycle latency, no bubbles.
REQ-029 relative offset 0 SHALL produce a self-loop (pc unchanged, count still increments).

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, pc=0, insnCount=0, running=0, done=0, independent of clk.
REQ-031 reset asserted mid-RUN SHALL abandon execution; after release block waits in IDLE for _start.
REQ-032 first edge after rst_n deassertion SHALL behave as a normal IDLE edge.

Structure
REQ-033 FSM enum (fetch_state_t) and COUNT_WIDTH (=16) SHALL live in the shared definitions package; DATA_WIDTH reused from it.
REQ-034 next-PC arithmetic (REQ-022..026) SHALL be one combinational sub-module, next_pc_calc; FSM, PC and counter registers in instruction_fetch.

Verification (DATA_WIDTH=8)
REQ-035 reset, _start with _startAddress=0x10, 3 plain cycles -> pc 0x10,0x11,0x12,0x13; insnCount=3; running=1.
REQ-036 pc=0x20, _branch=1, _relative=1, dest=0xFC: _compareFlag=1 -> pc=0x1C; _compareFlag=0 -> pc=0x21.
REQ-037 pc=0xFF plain -> 0x00; pc=0xF0 relative jump dest=0x20 -> 0x10; absolute jump dest=0x05 -> 0x05.
REQ-038 _halt=1 with _jump=1 at pc=0x30 -> HALTED, done=1, pc=0x30; later _start addr 0x00 -> RUN, pc=0x00, insnCount=0.
REQ-039 _stall=1 with _halt=1 for 2 cycles -> pc, insnCount unchanged, still RUN; drop _stall -> HALTED next edge.
REQ-040 rst_n low between edges mid-RUN at pc=0x44 -> pc=0, IDLE immediately; _start ignored while rst_n low.
